// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: accepts a PC, issues one word-aligned memory read at a time,
// and queues {pc, inst} pairs in a small FIFO for the decode stage.
module inst_fetch_unit #(
  parameter int INST_ADDR_WIDTH = 32,
  parameter int INST_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [INST_ADDR_WIDTH-1:0]         progCnter,
  input  logic                               chipEnable,
  output logic                               pcReady,
  input  logic                               flush,
  output logic                               memReq,
  output logic [INST_ADDR_WIDTH-1:0]         memAddr,
  input  logic                               memGnt,
  input  logic                               memRvalid,
  input  logic [INST_WIDTH-1:0]              memRdata,
  output logic                               instValid,
  output logic [INST_WIDTH-1:0]              instData,
  output logic [INST_ADDR_WIDTH-1:0]         instPc,
  input  logic                               instReady,
  output logic [1:0]                         dbgState,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    dbgCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e                       state_q;
  logic [INST_ADDR_WIDTH-1:0]   req_pc_q;
  logic                         mem_req_q;
  logic                         drop_q;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [INST_ADDR_WIDTH-1:0]   pc_mem   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0]        inst_mem [FIFO_DEPTH];
  logic                         push;
  logic                         pop;

  // Handshakes: progCnter transfers when chipEnable & pcReady; memory request transfers when
  // memReq & memGnt; decode pops when instValid & instReady. Producers hold values until transfer.
  assign pcReady = (state_q == IDLE) && chipEnable && (count_q < CNT_W'(FIFO_DEPTH)) && !flush;

  // Buffer room is checked at acceptance and only one fetch is ever in flight, so push never overflows.
  assign push = (state_q == WAIT) && memRvalid && !drop_q && !flush;
  assign pop  = instValid && instReady;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_pc_q  <= '0;
      mem_req_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pcReady) begin
            req_pc_q  <= progCnter;
            mem_req_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (memGnt) begin
            mem_req_q <= 1'b0;
            drop_q    <= flush;
            state_q   <= WAIT;
          end else if (flush) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        WAIT: begin
          if (memRvalid) begin
            drop_q  <= 1'b0;
            state_q <= IDLE;
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          drop_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= req_pc_q;
      inst_mem[wr_ptr_q] <= memRdata;
    end
  end

  assign memReq    = mem_req_q;
  assign memAddr   = {req_pc_q[INST_ADDR_WIDTH-1:2], 2'b00};
  assign instValid = (count_q != '0);
  assign instData  = instValid ? inst_mem[rd_ptr_q] : '0;
  assign instPc    = instValid ? pc_mem[rd_ptr_q] : '0;
  assign dbgState  = state_q;
  assign dbgCount  = count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: vector table of single fetches plus directed corner sequences,
// with a {pc, inst} scoreboard popped whenever decode takes the head.
module tb_inst_fetch_unit;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic        clock;
  logic        reset;
  logic [31:0] progCnter;
  logic        chipEnable;
  logic        pcReady;
  logic        flush;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        instValid;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic        instReady;
  logic [1:0]  dbgState;
  logic [1:0]  dbgCount;

  inst_fetch_unit #(
    .INST_ADDR_WIDTH(32),
    .INST_WIDTH     (32),
    .FIFO_DEPTH     (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .progCnter (progCnter),
    .chipEnable(chipEnable),
    .pcReady   (pcReady),
    .flush     (flush),
    .memReq    (memReq),
    .memAddr   (memAddr),
    .memGnt    (memGnt),
    .memRvalid (memRvalid),
    .memRdata  (memRdata),
    .instValid (instValid),
    .instData  (instData),
    .instPc    (instPc),
    .instReady (instReady),
    .dbgState  (dbgState),
    .dbgCount  (dbgCount)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_pc;
  logic [31:0] last_addr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Samples mid-cycle, then advances to the next negedge (one rising edge passes).
  task automatic tick();
    logic [63:0] e;
    #1;
    if (reset && !flush && instValid && instReady) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %0h inst %0h expected nothing", instPc, instData);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", {32'h0, instPc}, {32'h0, e[63:32]});
        check("pop_inst", {32'h0, instData}, {32'h0, e[31:0]});
      end
    end
    if (reset && !instValid) begin
      check("empty_zero", {instPc, instData}, 64'h0);
    end
    @(negedge clock);
  endtask

  // driver tasks
  task automatic accept(input logic [31:0] pc, input logic [31:0] exp_addr);
    progCnter  = pc;
    chipEnable = 1'b1;
    #1;
    check("pc_ready", {63'h0, pcReady}, 64'h1);
    tick();
    chipEnable = 1'b0;
    last_pc    = pc;
    last_addr  = exp_addr;
    check("req_state", {62'h0, dbgState}, {62'h0, S_REQ});
    check("mem_req", {63'h0, memReq}, 64'h1);
    check("mem_addr", {32'h0, memAddr}, {32'h0, exp_addr});
  endtask

  task automatic grant(input int n_wait);
    for (int i = 0; i < n_wait; i++) begin
      memGnt = 1'b0;
      tick();
      check("req_hold", {63'h0, memReq}, 64'h1);
      check("addr_stable", {32'h0, memAddr}, {32'h0, last_addr});
    end
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    check("wait_state", {62'h0, dbgState}, {62'h0, S_WAIT});
    check("req_drop", {63'h0, memReq}, 64'h0);
  endtask

  task automatic respond(input int n_delay, input logic [31:0] data, input bit expect_push);
    for (int i = 0; i < n_delay; i++) tick();
    memRvalid = 1'b1;
    memRdata  = data;
    if (expect_push) exp_q.push_back({last_pc, data});
    tick();
    memRvalid = 1'b0;
    memRdata  = $urandom;
    check("back_idle", {62'h0, dbgState}, {62'h0, S_IDLE});
  endtask

  initial begin
    logic [31:0] rpc;
    reset      = 1'b0;
    progCnter  = '0;
    chipEnable = 1'b0;
    flush      = 1'b0;
    memGnt     = 1'b0;
    memRvalid  = 1'b0;
    memRdata   = '0;
    instReady  = 1'b0;
    last_pc    = '0;
    last_addr  = '0;

    vecs[0] = '{32'h0000_0100, 32'h8C01_0004, 0, 0, 32'h0000_0100};
    vecs[1] = '{32'h0000_0206, 32'h1234_5678, 2, 1, 32'h0000_0204};
    vecs[2] = '{32'hFFFF_FFFF, 32'hA5A5_5A5A, 1, 3, 32'hFFFF_FFFC};
    vecs[3] = '{32'h0000_1003, 32'h0000_0000, 0, 2, 32'h0000_1000};
    vecs[4] = '{32'h8000_0001, 32'hFFFF_FFFF, 3, 0, 32'h8000_0000};

    // reset state
    @(negedge clock);
    #1;
    check("rst_mem_req", {63'h0, memReq}, 64'h0);
    check("rst_mem_addr", {32'h0, memAddr}, 64'h0);
    check("rst_inst_valid", {63'h0, instValid}, 64'h0);
    check("rst_inst", {instPc, instData}, 64'h0);
    check("rst_state", {62'h0, dbgState}, {62'h0, S_IDLE});
    check("rst_count", {62'h0, dbgCount}, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // single fetch, minimum latency: accepted at edge N, instValid in N+3
    instReady = 1'b0;
    accept(32'h100, 32'h100);
    grant(0);
    respond(0, 32'h8C01_0004, 1'b1);
    check("lat_valid", {63'h0, instValid}, 64'h1);
    check("lat_pc", {32'h0, instPc}, 64'h100);
    check("lat_inst", {32'h0, instData}, 64'h8C01_0004);
    instReady = 1'b1;
    tick();
    check("lat_drained", {62'h0, dbgCount}, 64'h0);

    // vector table with varied grant/response delays, decode always ready
    for (int v = 0; v < 5; v++) begin
      accept(vecs[v].pc, vecs[v].addr);
      grant(vecs[v].gnt_dly);
      respond(vecs[v].rv_dly, vecs[v].data, 1'b1);
    end
    for (int r = 0; r < 4; r++) begin
      rpc = $urandom;
      accept(rpc, {rpc[31:2], 2'b00});
      grant($urandom_range(0, 2));
      respond($urandom_range(0, 2), $urandom, 1'b1);
    end
    tick();
    tick();
    check("table_drained", {62'h0, dbgCount}, 64'h0);

    // full buffer: third PC refused until one pop
    instReady = 1'b0;
    accept(32'h0, 32'h0);
    grant(0);
    respond(0, 32'h1111_0000, 1'b1);
    accept(32'h4, 32'h4);
    grant(0);
    respond(0, 32'h2222_0004, 1'b1);
    check("full_count", {62'h0, dbgCount}, 64'h2);
    progCnter  = 32'h8;
    chipEnable = 1'b1;
    #1;
    check("full_pc_ready", {63'h0, pcReady}, 64'h0);
    tick();
    chipEnable = 1'b0;
    check("full_no_req", {63'h0, memReq}, 64'h0);
    check("full_idle", {62'h0, dbgState}, {62'h0, S_IDLE});
    instReady = 1'b1;
    tick();
    instReady = 1'b0;
    check("full_after_pop", {62'h0, dbgCount}, 64'h1);
    check("full_head", {32'h0, instPc}, 64'h4);
    accept(32'h8, 32'h8);
    grant(0);
    respond(0, 32'h3333_0008, 1'b1);
    instReady = 1'b1;
    tick();
    tick();
    check("full_drained", {62'h0, dbgCount}, 64'h0);

    // flush while waiting: response discarded
    accept(32'h200, 32'h200);
    grant(0);
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    check("flush_wait_state", {62'h0, dbgState}, {62'h0, S_WAIT});
    respond(1, 32'hDEAD_BEEF, 1'b0);
    check("flush_wait_count", {62'h0, dbgCount}, 64'h0);
    check("flush_wait_valid", {63'h0, instValid}, 64'h0);

    // flush coincident with the response
    accept(32'h300, 32'h300);
    grant(1);
    flush = 1'b1;
    respond(0, 32'hCAFE_F00D, 1'b0);
    flush = 1'b0;
    check("flush_rv_count", {62'h0, dbgCount}, 64'h0);

    // flush in REQ without grant: request withdrawn, stray rvalid ignored
    accept(32'h400, 32'h400);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_req_memreq", {63'h0, memReq}, 64'h0);
    check("flush_req_state", {62'h0, dbgState}, {62'h0, S_IDLE});
    memRvalid = 1'b1;
    memRdata  = 32'hBAD0_0400;
    tick();
    memRvalid = 1'b0;
    check("stray_rv_count", {62'h0, dbgCount}, 64'h0);

    // flush together with grant: drop the response
    accept(32'h500, 32'h500);
    flush  = 1'b1;
    memGnt = 1'b1;
    tick();
    flush  = 1'b0;
    memGnt = 1'b0;
    check("flush_gnt_state", {62'h0, dbgState}, {62'h0, S_WAIT});
    respond(0, 32'hBAD0_0500, 1'b0);
    check("flush_gnt_count", {62'h0, dbgCount}, 64'h0);

    // push/pop collision at count=1
    instReady = 1'b0;
    accept(32'h600, 32'h600);
    grant(1);
    respond(0, 32'h6000_0001, 1'b1);
    accept(32'h604, 32'h604);
    grant(0);
    instReady = 1'b1;
    respond(0, 32'h6040_0002, 1'b1);
    instReady = 1'b0;
    check("coll_count", {62'h0, dbgCount}, 64'h1);
    check("coll_pc", {32'h0, instPc}, 64'h604);
    check("coll_inst", {32'h0, instData}, 64'h6040_0002);
    instReady = 1'b1;
    tick();
    instReady = 1'b0;
    check("coll_drained", {62'h0, dbgCount}, 64'h0);

    // asynchronous reset mid-transaction
    accept(32'h700, 32'h700);
    grant(0);
    respond(0, 32'h7000_0000, 1'b1);
    accept(32'h704, 32'h704);
    grant(0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("arst_valid", {63'h0, instValid}, 64'h0);
    check("arst_inst", {instPc, instData}, 64'h0);
    check("arst_state", {62'h0, dbgState}, {62'h0, S_IDLE});
    check("arst_count", {62'h0, dbgCount}, 64'h0);
    check("arst_addr", {32'h0, memAddr}, 64'h0);
    check("arst_memreq", {63'h0, memReq}, 64'h0);
    @(negedge clock);
    reset     = 1'b1;
    memRvalid = 1'b1;
    memRdata  = 32'h7040_0000;
    tick();
    memRvalid = 1'b0;
    check("arst_no_push", {62'h0, dbgCount}, 64'h0);
    check("arst_idle", {62'h0, dbgState}, {62'h0, S_IDLE});

    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
